sysid_check_master: RTL and testbench

- Avalon-MM read master that interrogates the system-ID slave over the Qsys fabric.
- Runs after reset release (or on request):
  - reads the ID word at word offset 0;
  - reads the timestamp word at word offset 1;
  - compares both against build-time constants.
- Drives pass/fail status used by boot logic and LEDs to reject a mismatched FPGA image before the crypto datapath is enabled.

---
 rtl/sysid_check_pkg.sv | 25 ++
 rtl/sysid_check_master_if.sv | 28 ++
 rtl/sysid_timeout_ctr.sv | 32 +++
 rtl/sysid_check_master.sv | 134 +++++++++++++
 tb/tb_sysid_check_master.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check master: FSM states, word
// offsets inside the sysid slave and the default build-time expected values.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } state_t;

    localparam int unsigned ID_OFS = 0;
    localparam int unsigned TS_OFS = 1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1740595332;

    // A limit of 0 still needs a 1-bit counter so the port widths stay legal.
    function automatic int unsigned ctr_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM pipelined read bus between the sysid check master and the fabric.
interface sysid_check_master_if #(
    parameter int unsigned ADDR_W = 1
);

    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_waitrequest;
    logic [31:0]       av_readdata;
    logic              av_readdatavalid;

    modport master (
        output av_address,
        output av_read,
        input  av_waitrequest,
        input  av_readdata,
        input  av_readdatavalid
    );

    modport slave (
        input  av_address,
        input  av_read,
        output av_waitrequest,
        output av_readdata,
        output av_readdatavalid
    );

endinterface

// File: rtl/sysid_timeout_ctr.sv
// Clearable saturating per-read cycle counter; expired flags the cycle that
// is the LIMIT-th enabled cycle since the last clear. LIMIT of 0 never expires.
module sysid_timeout_ctr
    import sysid_check_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = ctr_width(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (32'(count) < LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Flag one edge early so the FSM leaves exactly LIMIT cycles after entry.
    assign expired = (LIMIT != 0) && enable && ((32'(count) + 32'd1) >= LIMIT);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words, compares
// them with build-time constants and reports pass/fail to the boot logic.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter int unsigned ADDR_W         = 1,
    parameter int unsigned BASE_ADDR      = 0,
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    sysid_check_master_if.master av,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_err,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);

    localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(BASE_ADDR + ID_OFS);
    localparam logic [ADDR_W-1:0] TS_ADDR = ADDR_W'(BASE_ADDR + TS_OFS);

    state_t state, state_nxt;
    logic   auto_pending;
    logic   ctr_clear;
    logic   ctr_enable;
    logic   expired;
    logic   in_req;
    logic   finishing;
    logic   ts_capture;

    assign in_req     = (state == ID_REQ) || (state == TS_REQ);
    assign ctr_enable = in_req || (state == ID_WAIT) || (state == TS_WAIT);
    assign ts_capture = (state == TS_WAIT) && av.av_readdatavalid;
    assign finishing  = ctr_enable && (state_nxt == DONE);

    assign av.av_read    = in_req;
    assign av.av_address = (state == ID_REQ) ? ID_ADDR :
                           (state == TS_REQ) ? TS_ADDR : '0;

    sysid_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .expired(expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arriving data wins over a timeout expiring in the same cycle.
    always_comb begin
        state_nxt = state;
        ctr_clear = 1'b0;
        unique case (state)
            IDLE: begin
                if (start || auto_pending) begin
                    state_nxt = ID_REQ;
                    ctr_clear = 1'b1;
                end
            end
            ID_REQ: begin
                if (expired)                  state_nxt = DONE;
                else if (!av.av_waitrequest)  state_nxt = ID_WAIT;
            end
            ID_WAIT: begin
                if (av.av_readdatavalid) begin
                    state_nxt = TS_REQ;
                    ctr_clear = 1'b1;
                end else if (expired) begin
                    state_nxt = DONE;
                end
            end
            TS_REQ: begin
                if (expired)                  state_nxt = DONE;
                else if (!av.av_waitrequest)  state_nxt = TS_WAIT;
            end
            TS_WAIT: begin
                if (av.av_readdatavalid || expired) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status is registered on the edge into DONE so the final timestamp can be
    // judged straight off the bus in the cycle it is captured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pending <= (AUTO_START != 0);
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            timeout_err  <= 1'b0;
            id_value     <= '0;
            ts_value     <= '0;
        end else begin
            if ((state == IDLE) && (state_nxt == ID_REQ)) begin
                auto_pending <= 1'b0;
                busy         <= 1'b1;
                done         <= 1'b0;
                pass         <= 1'b0;
                timeout_err  <= 1'b0;
            end
            if ((state == ID_WAIT) && av.av_readdatavalid) begin
                id_value <= av.av_readdata;
            end
            if (ts_capture) begin
                ts_value <= av.av_readdata;
            end
            if (finishing) begin
                busy        <= 1'b0;
                done        <= 1'b1;
                timeout_err <= !ts_capture;
                pass        <= ts_capture && (id_value == EXPECTED_ID) &&
                               (av.av_readdata == EXPECTED_TS);
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomised self-checking bench for sysid_check_master against a cycle-count
// and result model derived from the read/timeout rules.
module tb_sysid_check_master;
    import sysid_check_pkg::*;

    localparam int          ADDR_W    = 2;
    localparam int          BASE_ADDR = 3;
    localparam int          TMO       = 8;
    localparam logic [31:0] EXP_ID    = DEFAULT_EXPECTED_ID;
    localparam logic [31:0] EXP_TS    = DEFAULT_EXPECTED_TS;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        busy, done, pass, timeout_err;
    logic [31:0] id_value, ts_value;

    sysid_check_master_if #(.ADDR_W(ADDR_W)) bus ();

    sysid_check_master #(
        .ADDR_W        (ADDR_W),
        .BASE_ADDR     (BASE_ADDR),
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TMO),
        .AUTO_START    (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .av         (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout_err(timeout_err),
        .id_value   (id_value),
        .ts_value   (ts_value)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Slave configuration and observation
    int                wait_cycles = 0;
    int                rd_lat      = 1;
    logic [31:0]       id_data     = '0;
    logic [31:0]       ts_data     = '0;
    bit                drop_id     = 1'b0;
    bit                drop_ts     = 1'b0;
    int                accepted    = 0;
    int                stall_viol  = 0;
    logic [ADDR_W-1:0] acc_addr[$];

    // Model state: last captured words
    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Avalon slave: programmable waitrequest stretch and read latency
    int                s_wcnt = 0;
    int                s_cd   = 0;
    bit                s_pend = 1'b0;
    logic [31:0]       s_data = '0;
    bit                s_prev_wr = 1'b0;
    logic [ADDR_W-1:0] s_prev_addr = '0;
    logic [ADDR_W-1:0] s_ofs;
    initial begin
        bus.av_waitrequest   = 1'b0;
        bus.av_readdatavalid = 1'b0;
        bus.av_readdata      = '0;
        forever begin
            @(negedge clock);
            if (s_prev_wr && reset_n && (bus.av_read !== 1'b1 || bus.av_address !== s_prev_addr))
                stall_viol++;
            bus.av_readdatavalid = 1'b0;
            if (s_pend) begin
                if (s_cd == 0) begin
                    bus.av_readdatavalid = 1'b1;
                    bus.av_readdata      = s_data;
                    s_pend               = 1'b0;
                end else begin
                    s_cd--;
                end
            end
            bus.av_waitrequest = 1'b0;
            if (bus.av_read === 1'b1) begin
                if (s_wcnt < wait_cycles) begin
                    bus.av_waitrequest = 1'b1;
                    s_wcnt++;
                end else begin
                    s_wcnt = 0;
                    accepted++;
                    acc_addr.push_back(bus.av_address);
                    s_ofs = bus.av_address - ADDR_W'(BASE_ADDR);
                    if ((s_ofs == 0) ? !drop_id : !drop_ts) begin
                        s_pend = 1'b1;
                        s_cd   = rd_lat - 1;
                        s_data = (s_ofs == 0) ? id_data : ts_data;
                    end
                end
            end else begin
                s_wcnt = 0;
            end
            s_prev_wr   = bus.av_waitrequest;
            s_prev_addr = bus.av_address;
        end
    end

    // mode 0: start pulse; 1: reset then auto-start; 2: reset during ID_WAIT then auto-start
    task automatic apply_stimulus(input string tag, input int mode, input int w, input int lat,
                                  input logic [31:0] idd, input logic [31:0] tsd,
                                  input bit did, input bit dts, input bit extra_start);
        int   edges, exp_edges, dur, exp_acc;
        bit   id_to, ts_to, exp_to, exp_pass;
        logic [ADDR_W-1:0] a_id, a_ts;
        a_id = ADDR_W'(BASE_ADDR + 0);
        a_ts = ADDR_W'(BASE_ADDR + 1);

        wait_cycles = w; rd_lat = lat; id_data = idd; ts_data = tsd;
        drop_id = did; drop_ts = dts;

        if (mode == 1) begin
            @(negedge clock);
            reset_n = 1'b0;
            #1;
            m_id = '0; m_ts = '0;
            check_output({tag, ".rst_ctl"}, {27'd0, busy, done, pass, timeout_err, bus.av_read}, 32'd0);
            check_output({tag, ".rst_id"}, id_value, 32'd0);
            check_output({tag, ".rst_ts"}, ts_value, 32'd0);
            @(negedge clock);
            accepted = 0; acc_addr.delete(); stall_viol = 0;
            reset_n = 1'b1;
        end else if (mode == 2) begin
            wait_cycles = 0; rd_lat = 2; id_data = ~idd;
            @(negedge clock);
            start = 1'b1;
            @(posedge clock); #1 start = 1'b0;
            @(posedge clock);
            @(negedge clock);
            check_output({tag, ".busy_pre"}, {31'd0, busy}, 32'd1);
            reset_n = 1'b0;
            #1;
            m_id = '0; m_ts = '0;
            check_output({tag, ".rst_read"}, {31'd0, bus.av_read}, 32'd0);
            check_output({tag, ".rst_busy"}, {31'd0, busy}, 32'd0);
            @(negedge clock);
            wait_cycles = w; rd_lat = lat; id_data = idd;
            accepted = 0; acc_addr.delete(); stall_viol = 0;
            reset_n = 1'b1;
        end else begin
            accepted = 0; acc_addr.delete(); stall_viol = 0;
            @(negedge clock);
            start = 1'b1;
        end

        // Model: each read occupies 1 + w + lat cycles unless it exceeds the limit
        dur   = 1 + w + lat;
        id_to = did || (dur > TMO);
        ts_to = dts || (dur > TMO);
        if (id_to) begin
            exp_edges = 1 + TMO; exp_to = 1'b1; exp_acc = 1;
        end else begin
            m_id    = idd;
            exp_acc = 2;
            if (ts_to) begin
                exp_edges = 1 + dur + TMO; exp_to = 1'b1;
            end else begin
                exp_edges = 1 + 2 * dur; exp_to = 1'b0; m_ts = tsd;
            end
        end
        exp_pass = !exp_to && (m_id == EXP_ID) && (m_ts == EXP_TS);

        edges = 0;
        do begin
            @(posedge clock);
            edges++;
            #1 start = 1'b0;
            if (edges == 1) check_output({tag, ".busy"}, {31'd0, busy}, 32'd1);
            if (edges == 3 && extra_start) start = 1'b1;
        end while (done !== 1'b1 && edges < 100);

        check_output({tag, ".latency"}, edges, exp_edges);
        check_output({tag, ".done"}, {31'd0, done}, 32'd1);
        check_output({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        check_output({tag, ".pass"}, {31'd0, pass}, {31'd0, exp_pass});
        check_output({tag, ".tmo"}, {31'd0, timeout_err}, {31'd0, exp_to});
        check_output({tag, ".id"}, id_value, m_id);
        check_output({tag, ".ts"}, ts_value, m_ts);
        check_output({tag, ".stall"}, stall_viol, 0);
        if (acc_addr.size() > 0) check_output({tag, ".addr0"}, {30'd0, acc_addr[0]}, {30'd0, a_id});
        if (acc_addr.size() > 1) check_output({tag, ".addr1"}, {30'd0, acc_addr[1]}, {30'd0, a_ts});

        repeat (12) @(negedge clock);
        check_output({tag, ".reads"}, accepted, exp_acc);
        check_output({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, ".sticky"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int          w, lat;
        logic [31:0] idd, tsd;
        bit          did, dts;

        $display("[TB] sysid_check_master bench start");
        repeat (2) @(negedge clock);

        apply_stimulus("auto",      1, 0, 1, EXP_ID, EXP_TS,        0, 0, 0);
        apply_stimulus("bad_ts",    0, 0, 1, EXP_ID, 32'h12345678,  0, 0, 0);
        apply_stimulus("bad_id",    0, 0, 2, 32'hA5A5_0001, EXP_TS, 0, 0, 0);
        apply_stimulus("wait3",     0, 3, 1, EXP_ID, EXP_TS,        0, 0, 0);
        apply_stimulus("ts_drop",   0, 0, 1, EXP_ID, EXP_TS,        0, 1, 0);
        apply_stimulus("edge_ok",   0, 3, 4, EXP_ID, EXP_TS,        0, 0, 0);
        apply_stimulus("edge_tmo",  0, 3, 5, 32'h0BAD_0000, EXP_TS, 0, 0, 0);
        apply_stimulus("mid_reset", 2, 0, 1, EXP_ID, EXP_TS,        0, 0, 0);
        apply_stimulus("busy_start",0, 3, 1, EXP_ID, EXP_TS,        0, 0, 1);
        apply_stimulus("restart",   0, 0, 1, EXP_ID, EXP_TS,        0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            w   = $urandom_range(0, 4);
            lat = $urandom_range(1, 4);
            idd = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            tsd = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            did = ($urandom_range(0, 7) == 0);
            dts = ($urandom_range(0, 7) == 0);
            apply_stimulus($sformatf("rnd%0d", i), 0, w, lat, idd, tsd, did, dts, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
